// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer: next-PC select encoding,
// default vectors and the instruction-alignment mask helper.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEL_RESET,
        PC_SEL_TRAP,
        PC_SEL_REDIRECT,
        PC_SEL_PENDING,
        PC_SEL_HOLD,
        PC_SEL_INC
    } pc_sel_e;

    localparam int unsigned PC_DEFAULT_INSTR_BYTES  = 4;
    localparam logic [63:0] PC_DEFAULT_RESET_VECTOR = 64'h0;
    localparam logic [63:0] PC_DEFAULT_TRAP_VECTOR  = 64'h100;

    // Low-order bits that must be zero for an address to be instruction-aligned.
    function automatic int unsigned alignMask(input int unsigned instrBytes);
        return instrBytes - 1;
    endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// Single-entry holding register for a redirect target that arrived while fetch
// was stalled; used only when PC_REDIRECT_HOLD_EN is defined.
module pc_redirect_buffer
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // A load always overwrites the entry, so the newest redirect wins.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (load_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: reset/trap/redirect/hold/increment selection with
// misaligned-redirect rejection. PC_REDIRECT_HOLD_EN buffers redirects under stall.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      ADDR_W       = 64,
    parameter int unsigned      INSTR_BYTES  = PC_DEFAULT_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(PC_DEFAULT_TRAP_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              trap_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              redirect_pending_o,
    output logic              misaligned_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(alignMask(INSTR_BYTES));
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pcValid_q;
    logic              misaligned_q;
    logic              misRedirect;
    logic              alignedRedirect;
    pc_sel_e           pcSel;

    assign misRedirect     = redirect_valid_i && ((redirect_pc_i & ALIGN_MASK) != '0);
    assign alignedRedirect = redirect_valid_i && !misRedirect;

`ifdef PC_REDIRECT_HOLD_EN
    logic              pendingValid;
    logic [ADDR_W-1:0] pendingPc;
    logic              bufLoad;
    logic              bufClear;

    // Any unstalled edge either consumes or supersedes the entry; a trap drops it.
    assign bufLoad  = alignedRedirect && stall_i && !trap_i;
    assign bufClear = trap_i || !stall_i;

    pc_redirect_buffer #(
        .ADDR_W (ADDR_W)
    ) u_redirectBuffer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (bufLoad),
        .clear_i  (bufClear),
        .target_i (redirect_pc_i),
        .valid_o  (pendingValid),
        .target_o (pendingPc)
    );

    assign redirect_pending_o = pendingValid;
`else
    assign redirect_pending_o = 1'b0;
`endif

    always_comb begin
        pcSel = PC_SEL_INC;
        if (rst) begin
            pcSel = PC_SEL_RESET;
        end else if (trap_i) begin
            pcSel = PC_SEL_TRAP;
`ifdef PC_REDIRECT_HOLD_EN
        end else if (alignedRedirect && !stall_i) begin
            pcSel = PC_SEL_REDIRECT;
        end else if (stall_i) begin
            pcSel = PC_SEL_HOLD;
        end else if (pendingValid) begin
            pcSel = PC_SEL_PENDING;
`else
        end else if (alignedRedirect) begin
            pcSel = PC_SEL_REDIRECT;
        end else if (stall_i) begin
            pcSel = PC_SEL_HOLD;
`endif
        end
    end

    // Increment relies on natural ADDR_W-bit wraparound at the top of memory.
    always_comb begin
        pc_d = pc_q + PC_STEP;
        case (pcSel)
            PC_SEL_RESET:    pc_d = RESET_VECTOR;
            PC_SEL_TRAP:     pc_d = TRAP_VECTOR;
            PC_SEL_REDIRECT: pc_d = redirect_pc_i;
`ifdef PC_REDIRECT_HOLD_EN
            PC_SEL_PENDING:  pc_d = pendingPc;
`else
            PC_SEL_PENDING:  pc_d = pc_q;
`endif
            PC_SEL_HOLD:     pc_d = pc_q;
            default:         pc_d = pc_q + PC_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            pcValid_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pcValid_q    <= 1'b1;
            misaligned_q <= misRedirect;
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = pcValid_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the SIMD AES core front end; replaces the single PC register with a unit that generates the fetch address every cycle. Selects between reset vector, trap vector, redirect target, hold (stall) and sequential increment, and buffers a redirect that arrives while fetch is stalled. Sits between the branch/control unit and instruction memory; `pc_o` drives the fetch address directly.

## Interface
- `ADDR_W`, 64, PC width in bits (≥ 8).
- `INSTR_BYTES`, 4, instruction size in bytes; power of two, 1..16.
- `RESET_VECTOR`, 0, PC value loaded by reset; must be `INSTR_BYTES`-aligned.
- `TRAP_VECTOR`, 'h100, PC value loaded on trap; must be `INSTR_BYTES`-aligned.

- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — reset; synchronous, active-high.
- `stall_i` in 1 — 1 = hold PC this cycle.
- `redirect_valid_i` in 1 — 1 = branch/jump target presented this cycle.
- `redirect_pc_i` in ADDR_W — redirect target.
- `trap_i` in 1 — 1 = force PC to `TRAP_VECTOR`.
- `pc_o` out ADDR_W — current fetch PC (registered).
- `pc_valid_o` out 1 — `pc_o` is a fetchable address.
- `redirect_pending_o` out 1 — a buffered redirect is waiting for stall release.
- `misaligned_o` out 1 — one-cycle pulse: redirect target was rejected as misaligned.

## Operation
- Reset values: `pc_o` = `RESET_VECTOR`, `pc_valid_o` = 0, `redirect_pending_o` = 0, `misaligned_o` = 0; pending buffer cleared.
- `pc_valid_o` rises on the first rising edge with `rst` low and stays 1 until the next reset.
- Next-PC priority per edge, highest first: `rst` → `RESET_VECTOR`; `trap_i` → `TRAP_VECTOR` (ignores stall, clears pending); accepted redirect (see below); `stall_i` → hold; else `pc_o + INSTR_BYTES`.
- Increment is modulo 2^ADDR_W: all-ones-aligned PC wraps to 0 with no flag.
- Alignment: redirect with any of the low log2(`INSTR_BYTES`) bits set is dropped; `misaligned_o` = 1 the following cycle; PC follows the remaining priority chain. Misaligned redirect never enters the pending buffer.
- Aligned redirect with `stall_i` = 0: `pc_o` = target next cycle; any pending entry discarded.
- Aligned redirect with `stall_i` = 1: handled per `PC_REDIRECT_HOLD_EN` (Configuration).
- Pending buffer (one entry): on the first edge with `stall_i` = 0 and no trap, `pc_o` = pending target and buffer clears; a new aligned redirect in that same cycle wins over the pending entry. New redirect while pending overwrites the entry.
- Reset mid-operation: clears pending and any misalign pulse in the same edge.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Latency: redirect/trap/reset → `pc_o` update: 1 cycle. Stall release with pending → pending target on `pc_o` 1 cycle after `stall_i` falls.
- `redirect_pending_o` rises 1 cycle after a buffered redirect, falls in the cycle `pc_o` takes the target.
- `misaligned_o` is exactly one cycle per rejected redirect; back-to-back rejects keep it high.

## Configuration
- `PC_REDIRECT_HOLD_EN` defined: aligned redirect under stall is latched into the pending buffer, PC holds until stall releases.
- Not defined: no pending buffer; aligned redirect overrides stall and loads `pc_o` next cycle; `redirect_pending_o` tied 0.

## Structure
- Package `pc_pkg`: `pc_sel_e` enum (`PC_SEL_RESET`, `PC_SEL_TRAP`, `PC_SEL_REDIRECT`, `PC_SEL_PENDING`, `PC_SEL_HOLD`, `PC_SEL_INC`), alignment-mask helper function, default vector constants.
- Sub-module `pc_redirect_buffer`: single-entry valid+target register with load/overwrite/clear; instantiated only under `PC_REDIRECT_HOLD_EN`.

## Test plan
- Reset 3 cycles, release, 4 free cycles → `pc_o` 0,4,8,12,16; `pc_valid_o` 0 during reset, 1 from first released edge.
- At PC 0x20, `stall_i` 2 cycles → `pc_o` holds 0x20 two cycles, then 0x24.
- Stall at 0x40, redirect 0x800 during stall, release after 3 cycles → with macro: `redirect_pending_o` 1 for stall duration, then `pc_o` 0x800; without: `pc_o` 0x800 next cycle despite stall.
- Redirect to 0x802 → `pc_o` increments normally, `misaligned_o` pulses 1 cycle, no pending.
- Trap while stalled with pending 0x900 → `pc_o` 0x100 next cycle, `redirect_pending_o` 0, then 0x104 after stall release.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC, free-run → `pc_o` wraps to 0x0 then 0x4.
